// File: rtl/universal_shift_register.sv
// rtl/universal_shift_register.sv - WIDTH-bit universal shift register with load, shifts, rotates, clear
// Saturating shift counter and registered zero flag track the register contents.
module universal_shift_register #(
  parameter int          WIDTH       = 8,
  parameter logic [63:0] RESET_VALUE = '0,
  parameter int          CNT_WIDTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [2:0]           mode,
  input  logic [WIDTH-1:0]     d,
  input  logic                 sin_l,
  input  logic                 sin_r,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     qbar,
  output logic                 sout_l,
  output logic                 sout_r,
  output logic [CNT_WIDTH-1:0] shift_cnt,
  output logic                 zero
);

  localparam logic [WIDTH-1:0]     RST_Q   = RESET_VALUE[WIDTH-1:0];
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  localparam logic [2:0] M_HOLD  = 3'd0;
  localparam logic [2:0] M_LOAD  = 3'd1;
  localparam logic [2:0] M_SHL   = 3'd2;
  localparam logic [2:0] M_SHR   = 3'd3;
  localparam logic [2:0] M_ROL   = 3'd4;
  localparam logic [2:0] M_ROR   = 3'd5;
  localparam logic [2:0] M_ASR   = 3'd6;
  localparam logic [2:0] M_CLEAR = 3'd7;

  logic [WIDTH-1:0]     r_q;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_zero;

  logic [WIDTH-1:0]     w_q_next;
  logic                 w_cnt_clr;
  logic                 w_cnt_inc;

  always_comb begin
    w_q_next  = r_q;
    w_cnt_clr = 1'b0;
    w_cnt_inc = 1'b0;
    unique case (mode)
      M_HOLD:  w_q_next = r_q;
      M_LOAD:  begin
        w_q_next  = d;
        w_cnt_clr = 1'b1;
      end
      M_SHL:   begin
        w_q_next  = {r_q[WIDTH-2:0], sin_l};
        w_cnt_inc = 1'b1;
      end
      M_SHR:   begin
        w_q_next  = {sin_r, r_q[WIDTH-1:1]};
        w_cnt_inc = 1'b1;
      end
      M_ROL:   begin
        w_q_next  = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_cnt_inc = 1'b1;
      end
      M_ROR:   begin
        w_q_next  = {r_q[0], r_q[WIDTH-1:1]};
        w_cnt_inc = 1'b1;
      end
      M_ASR:   begin
        w_q_next  = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
        w_cnt_inc = 1'b1;
      end
      M_CLEAR: begin
        w_q_next  = '0;
        w_cnt_clr = 1'b1;
      end
      default: w_q_next = r_q;
    endcase
  end

  // zero is computed from the next-state value so it lines up with q
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q    <= RST_Q;
      r_cnt  <= '0;
      r_zero <= (RST_Q == '0);
    end else if (en) begin
      r_q    <= w_q_next;
      r_zero <= (w_q_next == '0);
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign q         = r_q;
  assign qbar      = ~r_q;
  assign sout_l    = r_q[WIDTH-1];
  assign sout_r    = r_q[0];
  assign shift_cnt = r_cnt;
  assign zero      = r_zero;

endmodule

// File: tb/tb_universal_shift_register.sv
// tb/tb_universal_shift_register.sv - directed self-checking bench for universal_shift_register
// Expected values are hand-computed for WIDTH=8, RESET_VALUE=A5, CNT_WIDTH=4.
module tb_universal_shift_register;

  localparam int WIDTH     = 8;
  localparam int CNT_WIDTH = 4;

  localparam logic [2:0] M_HOLD  = 3'd0;
  localparam logic [2:0] M_LOAD  = 3'd1;
  localparam logic [2:0] M_SHL   = 3'd2;
  localparam logic [2:0] M_SHR   = 3'd3;
  localparam logic [2:0] M_ROL   = 3'd4;
  localparam logic [2:0] M_ROR   = 3'd5;
  localparam logic [2:0] M_ASR   = 3'd6;
  localparam logic [2:0] M_CLEAR = 3'd7;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 en;
  logic [2:0]           mode;
  logic [WIDTH-1:0]     d;
  logic                 sin_l;
  logic                 sin_r;
  logic [WIDTH-1:0]     q;
  logic [WIDTH-1:0]     qbar;
  logic                 sout_l;
  logic                 sout_r;
  logic [CNT_WIDTH-1:0] shift_cnt;
  logic                 zero;

  int n_checks = 0;
  int n_errors = 0;

  universal_shift_register #(
    .WIDTH(WIDTH),
    .RESET_VALUE(64'hA5),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .mode(mode),
    .d(d),
    .sin_l(sin_l),
    .sin_r(sin_r),
    .q(q),
    .qbar(qbar),
    .sout_l(sout_l),
    .sout_r(sout_r),
    .shift_cnt(shift_cnt),
    .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled there too.
  task automatic tick(input logic [2:0] m);
    mode = m;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    d = v;
    tick(M_LOAD);
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b1;
    mode  = M_HOLD;
    d     = '0;
    sin_l = 1'b0;
    sin_r = 1'b0;
    #1;
    check("rst_q", q, 8'hA5);
    check("rst_qbar", qbar, 8'h5A);
    check("rst_cnt", shift_cnt, 0);
    check("rst_zero", zero, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    load(8'b1000_0001);
    check("load_q", q, 8'h81);
    check("load_cnt", shift_cnt, 0);
    check("load_soutl", sout_l, 1);
    sin_l = 1'b1;
    tick(M_SHL);
    check("shl_q", q, 8'h03);
    check("shl_soutl", sout_l, 0);
    check("shl_soutr", sout_r, 1);
    sin_r = 1'b1;
    tick(M_SHR);
    check("shr_q", q, 8'h81);
    check("shr_cnt", shift_cnt, 2);
    tick(M_HOLD);
    check("hold_q", q, 8'h81);
    check("hold_cnt", shift_cnt, 2);

    load(8'h81);
    tick(M_ROL);
    check("rol_q", q, 8'h03);
    tick(M_ROR);
    check("ror1_q", q, 8'h81);
    tick(M_ROR);
    check("ror2_q", q, 8'hC0);
    check("rot_cnt", shift_cnt, 3);
    load(8'h81);
    for (int i = 0; i < 8; i++) tick(M_ROL);
    check("rol8_q", q, 8'h81);
    check("rol8_cnt", shift_cnt, 8);

    sin_r = 1'b0;
    load(8'h80);
    tick(M_ASR);
    check("asr1_q", q, 8'hC0);
    for (int i = 0; i < 6; i++) tick(M_ASR);
    check("asr7_q", q, 8'hFF);
    check("asr7_cnt", shift_cnt, 7);
    check("asr7_qbar", qbar, 8'h00);
    load(8'h01);
    check("pre_zero", zero, 0);
    tick(M_SHR);
    check("shr0_q", q, 8'h00);
    check("shr0_zero", zero, 1);

    sin_l = 1'b1;
    for (int i = 0; i < 20; i++) tick(M_SHL);
    check("sat_q", q, 8'hFF);
    check("sat_cnt", shift_cnt, 15);
    check("sat_zero", zero, 0);
    en = 1'b0;
    tick(M_CLEAR);
    check("dis_clr_q", q, 8'hFF);
    check("dis_clr_cnt", shift_cnt, 15);
    d = 8'h12;
    tick(M_LOAD);
    check("dis_load_q", q, 8'hFF);
    check("dis_load_cnt", shift_cnt, 15);
    en = 1'b1;
    tick(M_CLEAR);
    check("clr_q", q, 8'h00);
    check("clr_cnt", shift_cnt, 0);
    check("clr_zero", zero, 1);

    load(8'h81);
    for (int i = 0; i < 3; i++) tick(M_ROL);
    check("pre_rst_q", q, 8'h0C);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_q", q, 8'hA5);
    check("mid_rst_cnt", shift_cnt, 0);
    check("mid_rst_zero", zero, 0);
    check("mid_rst_qbar", qbar, 8'h5A);
    @(posedge clk);
    #1;
    check("held_rst_q", q, 8'hA5);
    reset = 1'b0;
    load(8'h3C);
    check("post_rst_q", q, 8'h3C);
    check("post_rst_cnt", shift_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
Parametrised successor to the team's single-bit D flip-flop storage element. It provides a WIDTH-bit register with asynchronous reset to a programmable value, and the same inverted output convention (qbar). It adds synchronous clear, parallel load, logical/arithmetic shifts, rotates and a saturating shift counter. It is used as a general storage and serialisation primitive in student datapath labs (serial links, multipliers, LFSR front-ends).

Parameters:
WIDTH, 8, register width in bits; legal values 2..64.
RESET_VALUE, 0, value loaded into q on reset (WIDTH bits, upper bits truncated).
CNT_WIDTH, 4, width of shift counter; counter saturates at 2^CNT_WIDTH-1.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
en  input  1  clock enable; when 0, all state holds regardless of mode
mode  input  3  operation select (see Behaviour)
d  input  WIDTH  parallel load data
sin_l  input  1  serial input entering at bit 0 on shift-left
sin_r  input  1  serial input entering at bit WIDTH-1 on shift-right
q  output  WIDTH  register contents
qbar  output  WIDTH  bitwise inverse of q, combinational
sout_l  output  1  q[WIDTH-1], combinational
sout_r  output  1  q[0], combinational
shift_cnt  output  CNT_WIDTH  shifts/rotates since last load/clear/reset, saturating
zero  output  1  registered; 1 when q == 0

Behaviour:
- Reset (async, takes effect immediately, dominates all inputs): q = RESET_VALUE, shift_cnt = 0, zero = (RESET_VALUE == 0). Release is synchronous to the next rising clk edge; the first operation executes on the first edge with reset low.
- All updates occur on rising clk when reset = 0 and en = 1. Latency of every operation is 1 cycle: the new q is visible after the edge.
- mode encoding:
  - 0 HOLD: q unchanged; shift_cnt unchanged.
  - 1 LOAD: q = d; shift_cnt = 0.
  - 2 SHL: q = {q[WIDTH-2:0], sin_l}.
  - 3 SHR: q = {sin_r, q[WIDTH-1:1]}.
  - 4 ROL: q = {q[WIDTH-2:0], q[WIDTH-1]}.
  - 5 ROR: q = {q[0], q[WIDTH-1:1]}.
  - 6 ASR: q = {q[WIDTH-1], q[WIDTH-1:1]}; sign bit replicated, sin_r ignored.
  - 7 CLEAR: q = 0; shift_cnt = 0. This is a synchronous clear, distinct from reset.
- shift_cnt increments by 1 on every enabled edge in modes 2..6. At 2^CNT_WIDTH-1 it holds (saturates, no wrap).
- zero is a registered flag computed from the next-state value of q, so it is aligned with q on the same cycle, never one cycle late.
- en = 0: q, shift_cnt and zero hold in every mode, including LOAD and CLEAR.
- qbar, sout_l and sout_r are purely combinational from q, with no added latency.
- Rotates preserve popcount. Shifts discard the outgoing bit, which was visible on sout_l/sout_r before the edge.
- Reset asserted mid-operation: state is immediately forced to reset values; no partial update survives.
- No X propagation: all outputs are defined from reset onward.

Test Plan:
- Reset: WIDTH=8, RESET_VALUE=8'hA5, assert reset mid-cycle -> q=A5, qbar=5A, shift_cnt=0, zero=0, immediately without a clock edge.
- Load then SHL/SHR: LOAD d=8'b1000_0001, SHL with sin_l=1 -> q=0000_0011, sout_l=0; then SHR with sin_r=1 -> q=1000_0001; shift_cnt=2.
- Rotates: q=8'h81, ROL -> 03, ROR -> 81, ROR -> C0; after 8 ROLs from 81 -> 81 again with shift_cnt=8.
- ASR/zero: LOAD 8'h80, ASR x7 -> FF (sign fill); then LOAD 8'h01, SHR with sin_r=0 -> 00 with zero=1 in the same cycle.
- Enable/saturation: 20 SHL edges with CNT_WIDTH=4 -> shift_cnt holds at 15. Then en=0 with mode=CLEAR -> q and shift_cnt unchanged; en=1 CLEAR -> q=0, shift_cnt=0.
- Reset mid-stream: assert reset between edges during a run of ROLs -> q=RESET_VALUE immediately. First edge after release with mode=LOAD d=3C -> q=3C.
